bos_tx_framer: RTL and testbench

- Transmit-side packet framer for the host UART link. It is the outbound counterpart of the packet parser that consumes host frames.
- Arbitrates round-robin between per-source message FIFOs that hold complete messages.
- Emits each message as one frame: prefix, source address, destination address, length, payload, CRC.
- Drives the UART transmitter through a byte valid/ready handshake.

---
 rtl/bos_tx_framer.sv | 165 ++++++++++++++++
 tb/tb_bos_tx_framer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bos_tx_framer.sv
// rtl/bos_tx_framer.sv - round-robin message framer feeding the host UART transmitter
// Frame: prefix, source addr, dest addr, length, payload, CRC-8/0x07 over all preceding bytes.
`ifndef NUM_SOURCES
`define NUM_SOURCES 4
`endif

module bos_tx_framer #(
    parameter int         NUM_SRC   = `NUM_SOURCES,
    parameter logic [7:0] PREFIX    = 8'hDD,
    parameter logic [7:0] ADDR_BASE = 8'h01,
    parameter logic [7:0] HOST_ADDR = 8'h00
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_SRC-1:0]   have_msg_bus,
    input  logic [8*NUM_SRC-1:0] len_bus,
    input  logic [8*NUM_SRC-1:0] data_bus,
    output logic [NUM_SRC-1:0]   rdreq_bus,
    output logic [7:0]           tx_data,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    output logic [3:0]           current_source,
    output logic [2:0]           state,
    output logic [7:0]           crc
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PREFIX  = 3'd1,
        S_SRC     = 3'd2,
        S_DEST    = 3'd3,
        S_LEN     = 3'd4,
        S_PAYLOAD = 3'd5,
        S_CRC     = 3'd6
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] cur_q, cur_d;
    logic [3:0] rr_q, rr_d;
    logic [7:0] len_q, len_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] crc_q, crc_d;

    logic       grant_any, hi_any;
    logic [3:0] grant_idx, hi_idx, low_idx;
    logic [7:0] len_sel, data_sel;
    logic       xfer;

    function automatic logic [7:0] crc8_next(input logic [7:0] c, input logic [7:0] b);
        logic [7:0] x;
        x = c ^ b;
        for (int k = 0; k < 8; k++) begin
            x = x[7] ? ((x << 1) ^ 8'h07) : (x << 1);
        end
        return x;
    endfunction

    // Rotating priority: lowest pending index at or above rr_q, else wrap to lowest pending overall.
    always_comb begin
        hi_any  = 1'b0;
        hi_idx  = 4'd0;
        low_idx = 4'd0;
        grant_any = 1'b0;
        for (int j = NUM_SRC - 1; j >= 0; j--) begin
            if (have_msg_bus[j]) begin
                grant_any = 1'b1;
                low_idx   = 4'(j);
                if (4'(j) >= rr_q) begin
                    hi_any = 1'b1;
                    hi_idx = 4'(j);
                end
            end
        end
        grant_idx = hi_any ? hi_idx : low_idx;
    end

    always_comb begin
        len_sel   = 8'd0;
        data_sel  = 8'd0;
        rdreq_bus = '0;
        for (int j = 0; j < NUM_SRC; j++) begin
            if (grant_idx == 4'(j)) len_sel = len_bus[8*j +: 8];
            if (cur_q == 4'(j)) begin
                data_sel     = data_bus[8*j +: 8];
                rdreq_bus[j] = (state_q == S_PAYLOAD) && tx_ready;
            end
        end
    end

    always_comb begin
        case (state_q)
            S_PREFIX:  tx_data = PREFIX;
            S_SRC:     tx_data = ADDR_BASE + {4'd0, cur_q};
            S_DEST:    tx_data = HOST_ADDR;
            S_LEN:     tx_data = len_q;
            S_PAYLOAD: tx_data = data_sel;
            S_CRC:     tx_data = crc_q;
            default:   tx_data = 8'd0;
        endcase
    end

    assign tx_valid       = (state_q != S_IDLE);
    assign xfer           = tx_valid && tx_ready;
    assign current_source = cur_q;
    assign state          = state_q;
    assign crc            = crc_q;

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        rr_d    = rr_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        crc_d   = crc_q;
        case (state_q)
            S_IDLE: begin
                if (grant_any) begin
                    state_d = S_PREFIX;
                    cur_d   = grant_idx;
                    len_d   = len_sel;
                    crc_d   = 8'd0;
                    rr_d    = (grant_idx == 4'(NUM_SRC - 1)) ? 4'd0 : grant_idx + 4'd1;
                end
            end
            S_PREFIX: if (xfer) state_d = S_SRC;
            S_SRC:    if (xfer) state_d = S_DEST;
            S_DEST:   if (xfer) state_d = S_LEN;
            S_LEN: begin
                if (xfer) begin
                    cnt_d   = 8'd0;
                    state_d = (len_q != 8'd0) ? S_PAYLOAD : S_CRC;
                end
            end
            S_PAYLOAD: begin
                if (xfer) begin
                    if (cnt_q == len_q - 8'd1) state_d = S_CRC;
                    else                       cnt_d   = cnt_q + 8'd1;
                end
            end
            S_CRC:    if (xfer) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
        // The CRC byte itself is excluded from the running checksum.
        if (xfer && state_q != S_CRC) crc_d = crc8_next(crc_q, tx_data);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cur_q   <= 4'd0;
            rr_q    <= 4'd0;
            len_q   <= 8'd0;
            cnt_q   <= 8'd0;
            crc_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            rr_q    <= rr_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            crc_q   <= crc_d;
        end
    end

endmodule

// File: tb/tb_bos_tx_framer.sv
// tb/tb_bos_tx_framer.sv - randomized bench for bos_tx_framer against a message-level frame model
module tb_bos_tx_framer;
    localparam int NS = 4;
    localparam logic [7:0] PFX  = 8'hDD;
    localparam logic [7:0] ABASE = 8'h01;
    localparam logic [7:0] HOST = 8'h00;

    logic            clk, rst, tx_ready, tx_valid;
    logic [NS-1:0]   have_msg_bus, rdreq_bus;
    logic [8*NS-1:0] len_bus, data_bus;
    logic [7:0]      tx_data, crc;
    logic [3:0]      current_source;
    logic [2:0]      state;

    bos_tx_framer #(.NUM_SRC(NS), .PREFIX(PFX), .ADDR_BASE(ABASE), .HOST_ADDR(HOST)) dut (
        .clk(clk), .rst(rst), .have_msg_bus(have_msg_bus), .len_bus(len_bus),
        .data_bus(data_bus), .rdreq_bus(rdreq_bus), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .current_source(current_source), .state(state), .crc(crc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Source FIFO contents: concatenated payload bytes plus per-message lengths.
    logic [7:0] fdata[NS][$];
    int         flen[NS][$];
    int         ptr[NS];
    logic [7:0] exp_q[$];
    int         exp_src[$];
    int         exp_len[$];

    int   n_checks, n_pass;
    bit   rand_ready, prev_stall, in_gap;
    int   gap, rd_cnt, fr_bytes;
    logic [7:0] prev_data;
    logic [2:0] prev_state;

    task automatic check(input string tag, input int obs, input int expv);
        n_checks++;
        if (obs == expv) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, obs, obs, expv, expv, $time);
    endtask

    function automatic logic [7:0] crc8(input logic [7:0] c, input logic [7:0] b);
        logic [7:0] x;
        x = c ^ b;
        for (int k = 0; k < 8; k++) x = x[7] ? ((x << 1) ^ 8'h07) : (x << 1);
        return x;
    endfunction

    task automatic add_msg(input int s, input int len, input bit incr);
        for (int j = 0; j < len; j++) fdata[s].push_back(incr ? 8'(j + 1) : 8'($urandom));
        flen[s].push_back(len);
    endtask

    task automatic pop_msg(input int s);
        for (int j = 0; j < flen[s][0]; j++) void'(fdata[s].pop_front());
        void'(flen[s].pop_front());
        ptr[s] = 0;
    endtask

    task automatic drive_buses();
        for (int s = 0; s < NS; s++) begin
            have_msg_bus[s]    = (flen[s].size() > 0);
            len_bus[8*s +: 8]  = (flen[s].size() > 0) ? 8'(flen[s][0]) : 8'd0;
            data_bus[8*s +: 8] = (flen[s].size() > 0 && ptr[s] < flen[s][0]) ? fdata[s][ptr[s]] : 8'd0;
        end
    endtask

    // Expected stream: serve pending messages round-robin starting at source 0.
    task automatic build_expected();
        int cnt[NS];
        int off[NS];
        int rr, k, len;
        logic [7:0] c;
        logic [7:0] hdr[4];
        bit done;
        for (int s = 0; s < NS; s++) begin cnt[s] = flen[s].size(); off[s] = 0; end
        rr = 0;
        done = 0;
        while (!done) begin
            k = -1;
            for (int i = 0; i < NS; i++)
                if (k < 0 && cnt[(rr + i) % NS] > 0) k = (rr + i) % NS;
            if (k < 0) done = 1;
            else begin
                len = flen[k][flen[k].size() - cnt[k]];
                c = 8'd0;
                hdr[0] = PFX; hdr[1] = 8'(ABASE + k); hdr[2] = HOST; hdr[3] = 8'(len);
                for (int i = 0; i < 4; i++) begin exp_q.push_back(hdr[i]); c = crc8(c, hdr[i]); end
                for (int j = 0; j < len; j++) begin
                    exp_q.push_back(fdata[k][off[k] + j]);
                    c = crc8(c, fdata[k][off[k] + j]);
                end
                exp_q.push_back(c);
                exp_src.push_back(k);
                exp_len.push_back(len);
                cnt[k]--;
                off[k] += len;
                rr = (k + 1) % NS;
            end
        end
    endtask

    task automatic step();
        bit do_rd, do_pop;
        int rd_src, pop_src;
        do_rd = 0; do_pop = 0; rd_src = 0; pop_src = 0;
        @(negedge clk);
        if (prev_stall) begin
            check("hold_valid", tx_valid, 1);
            check("hold_data", tx_data, prev_data);
            check("hold_state", state, prev_state);
        end
        if (in_gap) begin
            if (tx_valid) begin check("idle_gap", gap, 1); in_gap = 0; end
            else gap++;
        end
        if (|rdreq_bus) begin
            rd_src = (exp_src.size() > 0) ? exp_src[0] : 0;
            check("rdreq_onehot", rdreq_bus, 1 << rd_src);
            rd_cnt++;
            do_rd = 1;
        end
        if (tx_valid && tx_ready) begin
            fr_bytes++;
            check("byte_expected", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) check("tx_byte", tx_data, exp_q.pop_front());
            if (state == 3'd6 && exp_src.size() > 0) begin
                check("frame_src", current_source, exp_src[0]);
                check("rdreq_cnt", rd_cnt, exp_len[0]);
                check("frame_bytes", fr_bytes, exp_len[0] + 5);
                pop_src = exp_src.pop_front();
                void'(exp_len.pop_front());
                do_pop = 1;
                rd_cnt = 0;
                fr_bytes = 0;
                in_gap = (exp_src.size() > 0);
                gap = 0;
            end
        end
        prev_stall = tx_valid && !tx_ready;
        prev_data  = tx_data;
        prev_state = state;
        @(posedge clk);
        #1;
        if (do_rd) ptr[rd_src]++;
        if (do_pop) pop_msg(pop_src);
        tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        drive_buses();
    endtask

    task automatic clear_env();
        for (int s = 0; s < NS; s++) begin fdata[s].delete(); flen[s].delete(); ptr[s] = 0; end
        exp_q.delete(); exp_src.delete(); exp_len.delete();
        prev_stall = 0; in_gap = 0; gap = 0; rd_cnt = 0; fr_bytes = 0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_valid"}, tx_valid, 0);
        check({tag, "_rdreq"}, rdreq_bus, 0);
        check({tag, "_state"}, state, 0);
        check({tag, "_crc"}, crc, 0);
        check({tag, "_src"}, current_source, 0);
    endtask

    task automatic start_scn(input bit rnd);
        rst = 1'b1;
        tx_ready = 1'b0;
        rand_ready = rnd;
        clear_env();
        drive_buses();
        @(posedge clk); #1;
        @(negedge clk);
        check_idle("reset");
        @(posedge clk); #1;
    endtask

    task automatic run(input int budget);
        int cyc;
        cyc = 0;
        while (exp_q.size() > 0 && cyc < budget) begin step(); cyc++; end
        check("drained", exp_q.size(), 0);
        @(negedge clk);
        check("idle_after_valid", tx_valid, 0);
        check("idle_after_state", state, 0);
    endtask

    task automatic go(input int budget);
        build_expected();
        drive_buses();
        rst = 1'b0;
        tx_ready = 1'b1;
        run(budget);
    endtask

    initial begin
        int cyc;
        n_checks = 0; n_pass = 0;
        rst = 1'b1; tx_ready = 1'b0; rand_ready = 0;
        have_msg_bus = '0; len_bus = '0; data_bus = '0;

        start_scn(0); add_msg(0, 6, 1); go(200);
        start_scn(0); add_msg(2, 0, 0); go(100);
        start_scn(0);
        for (int i = 0; i < 3; i++) begin
            add_msg(1, $urandom_range(1, 8), 0);
            add_msg(3, $urandom_range(1, 8), 0);
        end
        go(500);
        start_scn(1); add_msg(0, 6, 1); go(400);

        // Reset in the middle of a payload, then source 0 must win the next grant.
        start_scn(0); add_msg(1, 6, 0);
        build_expected(); drive_buses(); rst = 1'b0; tx_ready = 1'b1;
        cyc = 0;
        while (rd_cnt < 3 && cyc < 200) begin step(); cyc++; end
        check("reached_payload", rd_cnt, 3);
        tx_ready = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        tx_ready = 1'b1;
        @(negedge clk);
        check_idle("midreset");
        clear_env();
        add_msg(0, 4, 0); add_msg(1, 3, 0);
        build_expected(); drive_buses();
        run(300);

        start_scn(1); add_msg($urandom_range(0, NS - 1), 255, 0); go(3000);
        start_scn(1);
        for (int s = 0; s < NS; s++)
            for (int k = 0; k < 3; k++)
                if ($urandom_range(0, 1) == 1) add_msg(s, $urandom_range(0, 20), 0);
        add_msg(0, 0, 0);
        go(4000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
